// File: rtl/dfd_trace_unpacker_if.sv
// Handshake bundle between a trace accumulator, the unpacker and a bank writer.
//   line_*  : accumulator lines flowing into the unpacker (byte 0 in bits [7:0]).
//   bank_*  : bank-sized chunks flowing out of the unpacker (byte 0 in bits [7:0]).
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both 1. The source keeps data stable while valid=1
// and ready=0. Ready never depends combinationally on the same channel's valid.
//   master : the side that produces lines and consumes chunks.
//   slave  : the unpacker.
interface dfd_trace_unpacker_if #(
    parameter int ACC_BYTES  = 64,
    parameter int BANK_BYTES = 32
);
    logic                    line_valid;
    logic                    line_ready;
    logic [ACC_BYTES*8-1:0]  line_data;
    logic [ACC_BYTES-1:0]    line_byte_be;
    logic                    line_last;

    logic                    bank_valid;
    logic                    bank_ready;
    logic [BANK_BYTES*8-1:0] bank_data;
    logic [BANK_BYTES-1:0]   bank_byte_be;

    modport master (
        output line_valid, line_data, line_byte_be, line_last, bank_ready,
        input  line_ready, bank_valid, bank_data, bank_byte_be
    );

    modport slave (
        input  line_valid, line_data, line_byte_be, line_last, bank_ready,
        output line_ready, bank_valid, bank_data, bank_byte_be
    );
endinterface

// File: rtl/dfd_trace_unpacker.sv
// Unpacks wide accumulator lines into narrower bank chunks starting at an
// arbitrary byte offset. Two line slots (L0 current, L1 next) let a chunk
// straddle a line boundary. A line flagged last ends its segment: bytes past
// it are emitted as invalid and the next line is read from byte 0.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   start             : pulse, IDLE -> ACTIVE, loads read pointer from cfg_start_offset
//   cfg_start_offset  : first byte to read within the first line
//   flush             : pulse, drops all buffered lines and returns to IDLE
//   busy              : state is ACTIVE
//   dbg_state_o       : raw state register (0 = IDLE, 1 = ACTIVE)
//   bus               : line input and bank output handshakes
module dfd_trace_unpacker #(
    parameter int ACCUMULATOR_DATA_WIDTH_IN_BYTES = 64,
    parameter int BANK_DATA_WIDTH_IN_BYTES        = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic [$clog2(ACCUMULATOR_DATA_WIDTH_IN_BYTES)-1:0] cfg_start_offset,
    input  logic flush,
    output logic busy,
    output logic dbg_state_o,
    dfd_trace_unpacker_if.slave bus
);
    localparam int ACC  = ACCUMULATOR_DATA_WIDTH_IN_BYTES;
    localparam int BANK = BANK_DATA_WIDTH_IN_BYTES;
    localparam int PW   = $clog2(ACC);
    localparam logic [PW:0] ACC_X  = (PW+1)'(ACC);
    localparam logic [PW:0] BANK_X = (PW+1)'(BANK);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic                   l0_v_q, l0_v_d, l1_v_q, l1_v_d;
    logic                   l0_last_q, l0_last_d, l1_last_q, l1_last_d;
    logic [ACC-1:0][7:0]    l0_data_q, l0_data_d, l1_data_q, l1_data_d;
    logic [ACC-1:0]         l0_be_q, l0_be_d, l1_be_q, l1_be_d;

    logic                   active;
    logic [PW:0]            sum_x;
    logic                   fits, crosses;
    logic                   line_fire, bank_fire, pop;
    logic [PW:0]            src;
    logic [BANK-1:0][7:0]   bank_bytes;
    logic [BANK-1:0]        bank_be;

    assign active          = (state_q == ACTIVE);
    assign busy            = active;
    assign dbg_state_o     = logic'(state_q);
    // Depends only on registers, so no path from bank_ready.
    assign bus.line_ready  = active && !l1_v_q;

    // Pointer sum kept one bit wider so the line-boundary compare sees the carry.
    assign sum_x   = {1'b0, rd_ptr_q} + BANK_X;
    assign fits    = (sum_x <= ACC_X);
    assign crosses = (sum_x >= ACC_X);

    assign bus.bank_valid = active && l0_v_q && (fits || l1_v_q || l0_last_q);
    assign line_fire      = bus.line_valid && bus.line_ready && !flush;
    assign bank_fire      = bus.bank_valid && bus.bank_ready && !flush;
    assign pop            = bank_fire && crosses;

    // Byte extraction. Source indices below ACC come from L0, above from L1
    // unless L0 closes its segment, in which case the tail is empty. Every
    // byte is gated by its slot valid so empty slots show zero.
    always_comb begin
        src        = '0;
        bank_bytes = '0;
        bank_be    = '0;
        for (int i = 0; i < BANK; i++) begin
            src = {1'b0, rd_ptr_q} + (PW+1)'(i);
            if (!src[PW]) begin
                if (l0_v_q) begin
                    bank_bytes[i] = l0_data_q[src[PW-1:0]];
                    bank_be[i]    = l0_be_q[src[PW-1:0]];
                end
            end else if (l0_v_q && !l0_last_q && l1_v_q) begin
                bank_bytes[i] = l1_data_q[src[PW-1:0]];
                bank_be[i]    = l1_be_q[src[PW-1:0]];
            end
        end
    end

    assign bus.bank_data    = bank_bytes;
    assign bus.bank_byte_be = bank_be;

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        l0_v_d    = l0_v_q;
        l0_last_d = l0_last_q;
        l0_data_d = l0_data_q;
        l0_be_d   = l0_be_q;
        l1_v_d    = l1_v_q;
        l1_last_d = l1_last_q;
        l1_data_d = l1_data_q;
        l1_be_d   = l1_be_q;
        if (flush) begin
            state_d  = IDLE;
            rd_ptr_d = '0;
            l0_v_d   = 1'b0;
            l1_v_d   = 1'b0;
        end else if (!active) begin
            if (start) begin
                state_d  = ACTIVE;
                rd_ptr_d = cfg_start_offset;
            end
        end else begin
            if (bank_fire) begin
                // Ending a segment realigns the next one to byte 0.
                rd_ptr_d = (pop && l0_last_q) ? '0 : sum_x[PW-1:0];
            end
            if (pop) begin
                l0_v_d    = l1_v_q;
                l0_last_d = l1_last_q;
                l0_data_d = l1_data_q;
                l0_be_d   = l1_be_q;
                l1_v_d    = 1'b0;
            end
            // line_ready guarantees L1 is free, even after a pop.
            if (line_fire) begin
                if (!l0_v_d) begin
                    l0_v_d    = 1'b1;
                    l0_last_d = bus.line_last;
                    l0_data_d = bus.line_data;
                    l0_be_d   = bus.line_byte_be;
                end else begin
                    l1_v_d    = 1'b1;
                    l1_last_d = bus.line_last;
                    l1_data_d = bus.line_data;
                    l1_be_d   = bus.line_byte_be;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            l0_v_q    <= 1'b0;
            l0_last_q <= 1'b0;
            l0_data_q <= '0;
            l0_be_q   <= '0;
            l1_v_q    <= 1'b0;
            l1_last_q <= 1'b0;
            l1_data_q <= '0;
            l1_be_q   <= '0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            l0_v_q    <= l0_v_d;
            l0_last_q <= l0_last_d;
            l0_data_q <= l0_data_d;
            l0_be_q   <= l0_be_d;
            l1_v_q    <= l1_v_d;
            l1_last_q <= l1_last_d;
            l1_data_q <= l1_data_d;
            l1_be_q   <= l1_be_d;
        end
    end
endmodule

// File: tb/tb_dfd_trace_unpacker.sv
// Bench for dfd_trace_unpacker: directed table of single-line cases, hand
// sequences for multi-cycle corners, and randomized segments checked against
// a line-list reference model through an expected-chunk queue.
module tb_dfd_trace_unpacker;
    localparam int ACC  = 64;
    localparam int BANK = 32;
    localparam int EW   = BANK * 9;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic [5:0] cfg_start_offset;
    logic flush;
    logic busy;
    logic dbg_state;

    dfd_trace_unpacker_if #(.ACC_BYTES(ACC), .BANK_BYTES(BANK)) bus ();

    dfd_trace_unpacker #(
        .ACCUMULATOR_DATA_WIDTH_IN_BYTES(ACC),
        .BANK_DATA_WIDTH_IN_BYTES(BANK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .cfg_start_offset(cfg_start_offset),
        .flush(flush),
        .busy(busy),
        .dbg_state_o(dbg_state),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [EW-1:0]      exp_q[$];
    logic [ACC*8-1:0]   ln_data[16];
    logic [ACC-1:0]     ln_be[16];
    bit                 ln_last[16];
    int                 n_lines;
    int                 li;

    typedef struct {
        int             off;
        bit             last;
        bit             exp_valid;
        logic [BANK-1:0] exp_be;
    } vec_t;
    vec_t tab[8];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ACC*8-1:0] pat(input logic [7:0] base);
        logic [ACC*8-1:0] r;
        for (int k = 0; k < ACC; k++) r[k*8 +: 8] = base + 8'(k);
        return r;
    endfunction

    task automatic set_line(input int idx, input logic [ACC*8-1:0] d, input logic [ACC-1:0] be, input bit last);
        ln_data[idx] = d;
        ln_be[idx]   = be;
        ln_last[idx] = last;
    endtask

    // Reference model: walks the line list as a byte stream, one chunk per
    // BANK bytes, with segment ends padding the chunk and restarting at byte 0.
    task automatic build_expected(input int off);
        int p;
        int i;
        int s;
        logic [BANK*8-1:0] d;
        logic [BANK-1:0]   be;
        p = off;
        i = 0;
        while (i < n_lines) begin
            if (p + BANK > ACC && !ln_last[i] && i + 1 >= n_lines) break;
            for (int b = 0; b < BANK; b++) begin
                s = p + b;
                if (s < ACC) begin
                    d[b*8 +: 8] = ln_data[i][s*8 +: 8];
                    be[b]       = ln_be[i][s];
                end else if (!ln_last[i]) begin
                    d[b*8 +: 8] = ln_data[i+1][(s-ACC)*8 +: 8];
                    be[b]       = ln_be[i+1][s-ACC];
                end else begin
                    d[b*8 +: 8] = 8'h00;
                    be[b]       = 1'b0;
                end
            end
            exp_q.push_back({be, d});
            p = p + BANK;
            if (p >= ACC) begin
                p = ln_last[i] ? 0 : p - ACC;
                i++;
            end
        end
    endtask

    task automatic do_start(input int off);
        start            = 1'b1;
        cfg_start_offset = 6'(off);
        tick();
        start            = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Presents ln_*[li] for one edge; line_ready is expected to be high.
    task automatic send_line();
        bus.line_valid   = 1'b1;
        bus.line_data    = ln_data[li];
        bus.line_byte_be = ln_be[li];
        bus.line_last    = ln_last[li];
        @(negedge clk);
        chk("send_line_ready", 512'(bus.line_ready), 512'(1'b1));
        tick();
        bus.line_valid = 1'b0;
        li++;
    endtask

    // Feeds the remaining lines with random gaps and random bank_ready,
    // scoring every chunk against exp_q until both are exhausted.
    task automatic run_stream(input int budget);
        int cyc;
        logic [EW-1:0] e;
        cyc = 0;
        while ((li < n_lines || exp_q.size() != 0) && cyc < budget) begin
            @(negedge clk);
            if (bus.line_valid && bus.line_ready) li++;
            if (bus.bank_valid && bus.bank_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_chunk", 512'(bus.bank_valid), 512'(1'b0));
                end else begin
                    e = exp_q.pop_front();
                    chk("chunk_data", 512'(bus.bank_data), 512'(e[BANK*8-1:0]));
                    chk("chunk_be", 512'(bus.bank_byte_be), 512'(e[EW-1:BANK*8]));
                end
            end
            tick();
            bus.line_valid = (li < n_lines) && ($urandom_range(0, 3) != 0);
            if (li < n_lines) begin
                bus.line_data    = ln_data[li];
                bus.line_byte_be = ln_be[li];
                bus.line_last    = ln_last[li];
            end
            bus.bank_ready = ($urandom_range(0, 2) != 0);
            cyc++;
        end
        chk("stream_timeout", 512'(cyc >= budget), 512'(1'b0));
        chk("stream_lines_taken", 512'(li), 512'(n_lines));
        exp_q.delete();
        bus.line_valid = 1'b0;
        bus.bank_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ACC*8-1:0] a_pat;
        logic [ACC*8-1:0] b_pat;
        logic [BANK*8-1:0] exp_d;
        logic [BANK*8-1:0] held;

        tab[0] = '{off: 0,  last: 1'b0, exp_valid: 1'b1, exp_be: 32'hFFFF_FFFF};
        tab[1] = '{off: 32, last: 1'b0, exp_valid: 1'b1, exp_be: 32'hFFFF_FFFF};
        tab[2] = '{off: 48, last: 1'b0, exp_valid: 1'b0, exp_be: 32'h0000_0000};
        tab[3] = '{off: 40, last: 1'b1, exp_valid: 1'b1, exp_be: 32'h00FF_FFFF};
        tab[4] = '{off: 33, last: 1'b1, exp_valid: 1'b1, exp_be: 32'h7FFF_FFFF};
        tab[5] = '{off: 63, last: 1'b1, exp_valid: 1'b1, exp_be: 32'h0000_0001};
        tab[6] = '{off: 16, last: 1'b1, exp_valid: 1'b1, exp_be: 32'hFFFF_FFFF};
        tab[7] = '{off: 63, last: 1'b0, exp_valid: 1'b0, exp_be: 32'h0000_0000};

        a_pat = pat(8'h10);
        b_pat = pat(8'h80);

        reset            = 1'b1;
        start            = 1'b0;
        flush            = 1'b0;
        cfg_start_offset = '0;
        bus.line_valid   = 1'b0;
        bus.line_data    = '0;
        bus.line_byte_be = '0;
        bus.line_last    = 1'b0;
        bus.bank_ready   = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        @(negedge clk);
        chk("rst_busy", 512'(busy), 512'(1'b0));
        chk("rst_state", 512'(dbg_state), 512'(1'b0));
        chk("rst_line_ready", 512'(bus.line_ready), 512'(1'b0));
        chk("rst_bank_valid", 512'(bus.bank_valid), 512'(1'b0));
        chk("rst_bank_data", 512'(bus.bank_data), 512'(1'b0));
        chk("rst_bank_be", 512'(bus.bank_byte_be), 512'(1'b0));

        // Single-line table: first chunk visible without a second line.
        for (int t = 0; t < 8; t++) begin
            n_lines = 1;
            li      = 0;
            set_line(0, a_pat, '1, tab[t].last);
            do_start(tab[t].off);
            chk("tab_busy", 512'(busy), 512'(1'b1));
            send_line();
            @(negedge clk);
            chk("tab_valid", 512'(bus.bank_valid), 512'(tab[t].exp_valid));
            if (tab[t].exp_valid) begin
                for (int i = 0; i < BANK; i++)
                    exp_d[i*8 +: 8] = tab[t].exp_be[i] ? 8'(8'h10 + tab[t].off + i) : 8'h00;
                chk("tab_be", 512'(bus.bank_byte_be), 512'(tab[t].exp_be));
                chk("tab_data", 512'(bus.bank_data), 512'(exp_d));
            end
            tick();
            do_flush();
            @(negedge clk);
            chk("tab_flush_idle", 512'(busy), 512'(1'b0));
        end

        // Two full lines from offset 0: four chunks in order.
        n_lines = 2; li = 0;
        set_line(0, a_pat, '1, 1'b0);
        set_line(1, b_pat, '1, 1'b0);
        build_expected(0);
        do_start(0);
        run_stream(400);
        tick();
        do_flush();

        // Offset 48: chunk waits for the second line, straddles, then rd_ptr=16.
        n_lines = 2; li = 0;
        set_line(0, a_pat, '1, 1'b0);
        set_line(1, b_pat, '1, 1'b0);
        do_start(48);
        send_line();
        start            = 1'b1;
        cfg_start_offset = 6'd0;
        tick();
        start            = 1'b0;
        @(negedge clk);
        chk("straddle_wait", 512'(bus.bank_valid), 512'(1'b0));
        tick();
        send_line();
        @(negedge clk);
        chk("straddle_valid", 512'(bus.bank_valid), 512'(1'b1));
        chk("straddle_data", 512'(bus.bank_data), 512'({b_pat[127:0], a_pat[511:384]}));
        chk("straddle_be", 512'(bus.bank_byte_be), 512'(32'hFFFF_FFFF));
        tick();
        bus.bank_ready = 1'b1;
        tick();
        bus.bank_ready = 1'b0;
        @(negedge clk);
        chk("ptr16_valid", 512'(bus.bank_valid), 512'(1'b1));
        chk("ptr16_data", 512'(bus.bank_data), 512'(b_pat[383:128]));
        tick();
        do_flush();

        // Segment end at offset 40, next line restarts at byte 0.
        n_lines = 2; li = 0;
        set_line(0, a_pat, '1, 1'b1);
        set_line(1, b_pat, '1, 1'b1);
        build_expected(40);
        do_start(40);
        run_stream(400);
        tick();
        do_flush();

        // Backpressure with both slots full: outputs hold, no line taken.
        n_lines = 3; li = 0;
        set_line(0, a_pat, '1, 1'b0);
        set_line(1, b_pat, '1, 1'b0);
        set_line(2, pat(8'h40), '1, 1'b0);
        build_expected(0);
        do_start(0);
        send_line();
        send_line();
        bus.line_valid   = 1'b1;
        bus.line_data    = ln_data[2];
        bus.line_byte_be = ln_be[2];
        bus.line_last    = ln_last[2];
        held = a_pat[255:0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_line_ready", 512'(bus.line_ready), 512'(1'b0));
            chk("bp_bank_valid", 512'(bus.bank_valid), 512'(1'b1));
            chk("bp_bank_data", 512'(bus.bank_data), 512'(held));
            tick();
        end
        run_stream(400);
        tick();
        do_flush();

        // Flush colliding with a line offer and a bank handshake.
        n_lines = 1; li = 0;
        set_line(0, a_pat, '1, 1'b0);
        do_start(0);
        send_line();
        bus.line_valid   = 1'b1;
        bus.line_data    = b_pat;
        bus.line_byte_be = '1;
        bus.line_last    = 1'b0;
        bus.bank_ready   = 1'b1;
        flush            = 1'b1;
        tick();
        flush          = 1'b0;
        bus.line_valid = 1'b0;
        bus.bank_ready = 1'b0;
        @(negedge clk);
        chk("flush_busy", 512'(busy), 512'(1'b0));
        chk("flush_bank_valid", 512'(bus.bank_valid), 512'(1'b0));
        chk("flush_line_ready", 512'(bus.line_ready), 512'(1'b0));
        tick();
        n_lines = 1; li = 0;
        set_line(0, pat(8'hC0), '1, 1'b1);
        build_expected(0);
        do_start(0);
        run_stream(400);
        tick();
        do_flush();

        // Reset with both slots full; only new lines afterwards.
        n_lines = 2; li = 0;
        set_line(0, a_pat, '1, 1'b0);
        set_line(1, b_pat, '1, 1'b0);
        do_start(8);
        send_line();
        send_line();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 512'(busy), 512'(1'b0));
        chk("mid_rst_line_ready", 512'(bus.line_ready), 512'(1'b0));
        chk("mid_rst_bank_valid", 512'(bus.bank_valid), 512'(1'b0));
        chk("mid_rst_bank_data", 512'(bus.bank_data), 512'(1'b0));
        chk("mid_rst_bank_be", 512'(bus.bank_byte_be), 512'(1'b0));
        tick();
        n_lines = 1; li = 0;
        set_line(0, pat(8'h20), '1, 1'b1);
        build_expected(0);
        do_start(0);
        run_stream(400);
        tick();
        do_flush();

        // Randomized segments.
        for (int r = 0; r < 8; r++) begin
            int off;
            n_lines = $urandom_range(2, 12);
            li      = 0;
            for (int k = 0; k < n_lines; k++) begin
                for (int w = 0; w < ACC / 4; w++) ln_data[k][w*32 +: 32] = $urandom;
                if ($urandom_range(0, 1) == 0) ln_be[k] = '1;
                else ln_be[k] = {$urandom, $urandom};
                ln_last[k] = ($urandom_range(0, 3) == 0);
            end
            ln_last[n_lines-1] = 1'b1;
            off = $urandom_range(0, ACC - 1);
            build_expected(off);
            do_start(off);
            run_stream(3000);
            @(negedge clk);
            chk("rand_drained_valid", 512'(bus.bank_valid), 512'(1'b0));
            chk("rand_busy", 512'(busy), 512'(1'b1));
            tick();
            do_flush();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dfd_trace_unpacker.md
DFD_TRACE_UNPACKER -- requirements
Module: dfd_trace_unpacker

Interface
REQ-001 SHALL have parameter ACCUMULATOR_DATA_WIDTH_IN_BYTES, default 64: input line width in bytes (power of 2).
REQ-002 SHALL have parameter BANK_DATA_WIDTH_IN_BYTES, default 32: output chunk width in bytes (power of 2, at most ACCUMULATOR_DATA_WIDTH_IN_BYTES).
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk input 1, the single clock; reset input 1, synchronous active-high reset.
REQ-004 start  input  1: pulse; in IDLE loads read pointer from cfg_start_offset and enters ACTIVE.
REQ-005 cfg_start_offset  input  $clog2(ACC bytes): initial read byte boundary within the first line.
REQ-006 flush  input  1: pulse; discards all buffered state and returns to IDLE.
REQ-007 line_valid / line_ready  input / output  1 each: accumulator-line handshake.
REQ-008 line_data  input  ACC*8: line bytes, byte 0 in bits [7:0].
REQ-009 line_byte_be  input  ACC: per-byte valid mask for line_data.
REQ-010 line_last  input  1: line terminates a trace segment.
REQ-011 bank_valid / bank_ready  output / input  1 each: chunk handshake.
REQ-012 bank_data  output  BANK*8: extracted chunk, byte 0 in bits [7:0].
REQ-013 bank_byte_be  output  BANK: per-byte valid mask for bank_data.
REQ-014 busy  output  1: high when the state is ACTIVE.

Function
REQ-015 SHALL implement states IDLE and ACTIVE.
- IDLE->ACTIVE on start.
- ACTIVE->IDLE on flush.
- start in ACTIVE SHALL be ignored.
REQ-016 SHALL hold two line slots (L0 = current, L1 = next), each with a valid bit, data, byte enables and last flag, plus read pointer rd_ptr of $clog2(ACC) bits.
REQ-017 line_ready SHALL be 1 only in ACTIVE with L1 empty; it SHALL have no combinational path from bank_ready.
REQ-018 An accepted line SHALL fill L0 if L0 is empty after this cycle's pop, else L1.
REQ-019 Output byte i (0..BANK-1) SHALL come from source index s = rd_ptr+i:
- s < ACC: L0 byte s.
- otherwise, if L0 is not last: L1 byte s-ACC.
- otherwise (L0 last): data 0, byte enable 0.
REQ-020 bank_valid SHALL equal ACTIVE and L0 valid and (rd_ptr+BANK <= ACC, or L1 valid, or L0 last).
REQ-021 bank_data and bank_byte_be SHALL be driven combinationally from registered slots; an accepted line is first visible on bank_* the cycle after its acceptance.
REQ-022 On a bank handshake, rd_ptr SHALL advance by BANK modulo ACC, computed with one extra bit, no truncation before the compare.
REQ-023 On a bank handshake with rd_ptr+BANK >= ACC, L0 SHALL be popped and L1 SHALL shift into L0 in the same cycle.
REQ-024 Popping a line with last=1 SHALL set rd_ptr to 0 regardless of the REQ-022 result, realigning the next segment.
REQ-025 Simultaneous pop and line accept with L1 full SHALL be impossible (REQ-017); pop and accept with L1 empty SHALL leave the new line in L0 or L1 per REQ-018.
REQ-026 bank_data and bank_byte_be SHALL be held stable while bank_valid=1 and bank_ready=0.
REQ-027 flush SHALL have priority over start and both handshakes.
- Clears both slot valid bits, rd_ptr and state.
- Any line presented in the flush cycle SHALL NOT be accepted.

Reset
REQ-028 On reset, state SHALL be IDLE, slots empty, rd_ptr=0, line_ready=0, bank_valid=0, busy=0, bank_data=0 and bank_byte_be=0.
REQ-029 Reset asserted mid-operation SHALL discard in-flight lines, with no bank handshake in the reset cycle.

Verification
REQ-030 start, offset 0; two lines A and B, all bytes valid, neither last -> chunks in order: A[31:0], A[63:32], B[31:0], B[63:32]; L0 pops on the 2nd and 4th handshakes.
REQ-031 start, offset 48; line A (not last), then line B -> first bank_valid only after B is buffered; chunk 1 = {B[15:0], A[63:48]}; rd_ptr becomes 16.
REQ-032 start, offset 40; line A with last=1 -> single chunk: bytes 0..23 = A[63:40], bank_byte_be = 0x00FFFFFF; then rd_ptr=0, and the next line starts at byte 0.
REQ-033 bank_ready held 0 for 5 cycles with L0 and L1 full -> line_ready=0, bank outputs stable, no lines lost.
REQ-034 flush in the same cycle as line_valid and bank handshake -> no line accepted, no rd_ptr advance, next cycle state IDLE with bank_valid=0.
REQ-035 Reset mid-stream with both slots full -> next cycle all outputs at their REQ-028 values; after start, only new lines appear.
